// File: rtl/ks_result_checker_if.sv
// Stimulus, adder-response and result signals of the adder result checker.
interface ks_result_checker_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             stop;
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [WIDTH-1:0] dut_sum;
   logic             dut_cout;
   logic             busy;
   logic             done;
   logic             mismatch;
   logic [15:0]      chk_cnt;
   logic [15:0]      err_cnt;
   logic [WIDTH:0]   first_exp;
   logic [WIDTH:0]   first_got;

   modport master (
      output start, stop, in_valid, a, b, cin, dut_sum, dut_cout,
      input  busy, done, mismatch, chk_cnt, err_cnt, first_exp, first_got
   );

   modport slave (
      input  start, stop, in_valid, a, b, cin, dut_sum, dut_cout,
      output busy, done, mismatch, chk_cnt, err_cnt, first_exp, first_got
   );
endinterface

// File: rtl/ks_result_checker.sv
// Checks an external adder against a+b+cin; the compare runs LATENCY cycles after acceptance
// and its result registers one cycle later. No backpressure: every accepted vector is compared.
module ks_result_checker #(
   parameter int WIDTH   = 16,
   parameter int LATENCY = 1
) (
   input logic                clk,
   input logic                rst,
   ks_result_checker_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [2:0]     drain_cnt_q, drain_cnt_d;
   logic           sess_clr, acc, drain_last;
   logic           busy_d, done_d;
   logic [WIDTH:0] exp_in, cmp_exp, cmp_got;
   logic           cmp_vld, cmp_fail;
   logic           mismatch_q, first_seen_q;
   logic [15:0]    chk_cnt_q, err_cnt_q;
   logic [WIDTH:0] first_exp_q, first_got_q;

   assign sess_clr   = bus.start && (state_q == S_IDLE || state_q == S_DONE);
   assign acc        = bus.in_valid && (state_q == S_RUN);
   // DRAIN lasts max(LATENCY,1) cycles: just long enough for the last vector to retire.
   assign drain_last = (int'(drain_cnt_q) + 1 >= LATENCY);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = '0;
      case (state_q)
         S_IDLE, S_DONE: if (bus.start) state_d = S_RUN;
         S_RUN:          if (bus.stop) state_d = S_DRAIN;
         S_DRAIN: begin
            if (drain_last) state_d = S_DONE;
            else            drain_cnt_d = drain_cnt_q + 3'd1;
         end
         default:        state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_d = (state_q == S_RUN) || (state_q == S_DRAIN);
      done_d = (state_q == S_DONE);
   end

   assign exp_in = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};

   generate
      if (LATENCY == 0) begin : g_nopipe
         assign cmp_exp = exp_in;
         assign cmp_vld = acc;
      end else begin : g_pipe
         logic [WIDTH:0]     exp_q [LATENCY];
         logic [LATENCY-1:0] vld_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q <= '0;
            end else begin
               vld_q[0] <= acc;
               for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            exp_q[0] <= exp_in;
            for (int i = 1; i < LATENCY; i++) exp_q[i] <= exp_q[i-1];
         end

         assign cmp_exp = exp_q[LATENCY-1];
         assign cmp_vld = vld_q[LATENCY-1];
      end
   endgenerate

   assign cmp_got  = {bus.dut_cout, bus.dut_sum};
   assign cmp_fail = cmp_vld && (cmp_got != cmp_exp);

   always_ff @(posedge clk) begin
      if (rst || sess_clr) begin
         mismatch_q   <= 1'b0;
         first_seen_q <= 1'b0;
         chk_cnt_q    <= '0;
         err_cnt_q    <= '0;
         first_exp_q  <= '0;
         first_got_q  <= '0;
      end else begin
         mismatch_q <= cmp_fail;
         if (cmp_vld && chk_cnt_q != 16'hFFFF) chk_cnt_q <= chk_cnt_q + 16'd1;
         if (cmp_fail) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            if (!first_seen_q) begin
               first_seen_q <= 1'b1;
               first_exp_q  <= cmp_exp;
               first_got_q  <= cmp_got;
            end
         end
      end
   end

   assign bus.busy      = busy_d;
   assign bus.done      = done_d;
   assign bus.mismatch  = mismatch_q;
   assign bus.chk_cnt   = chk_cnt_q;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.first_exp = first_exp_q;
   assign bus.first_got = first_got_q;
endmodule

// File: tb/tb_ks_result_checker.sv
// Directed bench for ks_result_checker (WIDTH=16, LATENCY=1) with a one-cycle adder model.
module tb_ks_result_checker;
   logic        clk = 1'b0;
   logic        rst;
   logic        bad_en;
   logic [16:0] bad_val;
   logic [16:0] resp_q;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          mism_total = 0;
   int          mbase;

   logic [15:0] va [6] = '{16'h0000, 16'h1111, 16'h0101, 16'hffff, 16'hffff, 16'hffff};
   logic [15:0] vb [6] = '{16'h1111, 16'h0000, 16'h0000, 16'hffff, 16'hffff, 16'h0000};
   logic        vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [16:0] ve [6] = '{17'h01111, 17'h01111, 17'h00102, 17'h1FFFE, 17'h1FFFF, 17'h10000};

   always #5 clk = ~clk;

   ks_result_checker_if #(.WIDTH(16)) bus ();

   ks_result_checker #(.WIDTH(16), .LATENCY(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Adder under test: one-cycle latency, optionally replaced by a faulty response.
   always @(posedge clk)
      resp_q <= bad_en ? bad_val : ({1'b0, bus.a} + {1'b0, bus.b} + {16'd0, bus.cin});
   assign bus.dut_sum  = resp_q[15:0];
   assign bus.dut_cout = resp_q[16];

   always @(negedge clk) if (bus.mismatch === 1'b1) mism_total++;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input logic v, input logic [15:0] av, input logic [15:0] bv,
                          input logic c);
      bus.in_valid = v;
      bus.a        = av;
      bus.b        = bv;
      bus.cin      = c;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      rst = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
      bad_en = 1'b0; bad_val = '0;
      set_vec(1'b0, 16'h0, 16'h0, 1'b0);
      cycle(); cycle();
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_mismatch", 32'(bus.mismatch), 0);
      chk("rst_chk", 32'(bus.chk_cnt), 0);
      chk("rst_err", 32'(bus.err_cnt), 0);
      chk("rst_fexp", 32'(bus.first_exp), 0);
      chk("rst_fgot", 32'(bus.first_got), 0);
      rst = 1'b0;
      cycle();
      set_vec(1'b1, 16'h1234, 16'h1111, 1'b0);
      cycle();
      chk("idle_ignores_valid", 32'(bus.busy), 0);

      // Pass run: six correct vectors, stop with the last one.
      set_vec(1'b0, 16'h0, 16'h0, 1'b0);
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      chk("run_busy", 32'(bus.busy), 1);
      mbase = mism_total;
      for (int i = 0; i < 6; i++) begin
         set_vec(1'b1, va[i], vb[i], vc[i]);
         bus.stop = (i == 5);
         cycle();
      end
      bus.stop = 1'b0;
      set_vec(1'b1, 16'h0001, 16'h0001, 1'b0);
      chk("drain_not_done", 32'(bus.done), 0);
      chk("drain_busy", 32'(bus.busy), 1);
      chk("drain_chk5", 32'(bus.chk_cnt), 5);
      cycle();
      chk("pass_done", 32'(bus.done), 1);
      chk("pass_chk", 32'(bus.chk_cnt), 6);
      chk("pass_err", 32'(bus.err_cnt), 0);
      cycle();
      set_vec(1'b0, 16'h0, 16'h0, 1'b0);
      cycle();
      chk("drain_valid_ignored", 32'(bus.chk_cnt), 6);
      chk("pass_no_mismatch", 32'(mism_total - mbase), 0);

      // Expected-value table: each vector answered with 0 in its own session.
      for (int i = 0; i < 6; i++) begin
         bus.start = 1'b1;
         cycle();
         bus.start = 1'b0;
         chk("sess_clr_fexp", 32'(bus.first_exp), 0);
         chk("sess_clr_chk", 32'(bus.chk_cnt), 0);
         set_vec(1'b1, va[i], vb[i], vc[i]);
         bad_en = 1'b1; bad_val = 17'h00000; bus.stop = 1'b1;
         cycle();
         set_vec(1'b0, 16'h0, 16'h0, 1'b0);
         bad_en = 1'b0; bus.stop = 1'b0;
         cycle();
         chk($sformatf("exp_done%0d", i), 32'(bus.done), 1);
         chk($sformatf("exp_val%0d", i), 32'(bus.first_exp), 32'(ve[i]));
         chk($sformatf("exp_got%0d", i), 32'(bus.first_got), 0);
         chk($sformatf("exp_err%0d", i), 32'(bus.err_cnt), 1);
      end

      // Error injection and mismatch timing.
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      mbase = mism_total;
      set_vec(1'b1, 16'hffff, 16'h0000, 1'b1);
      bad_en = 1'b1; bad_val = 17'h00000;
      cycle();
      set_vec(1'b0, 16'h0, 16'h0, 1'b0);
      bad_en = 1'b0;
      chk("inj_mis_t1", 32'(bus.mismatch), 0);
      cycle();
      chk("inj_mis_t2", 32'(bus.mismatch), 1);
      cycle();
      chk("inj_mis_t3", 32'(bus.mismatch), 0);
      chk("inj_pulses", 32'(mism_total - mbase), 1);
      chk("inj_err", 32'(bus.err_cnt), 1);
      chk("inj_fexp", 32'(bus.first_exp), 32'h10000);
      chk("inj_fgot", 32'(bus.first_got), 0);
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      chk("start_in_run_ignored", 32'(bus.err_cnt), 1);
      set_vec(1'b1, 16'h0001, 16'h0001, 1'b0);
      bad_en = 1'b1; bad_val = 17'h00005;
      cycle();
      set_vec(1'b0, 16'h0, 16'h0, 1'b0);
      bad_en = 1'b0;
      cycle();
      chk("inj2_err", 32'(bus.err_cnt), 2);
      chk("inj2_chk", 32'(bus.chk_cnt), 2);
      chk("inj2_fexp_held", 32'(bus.first_exp), 32'h10000);
      chk("inj2_fgot_held", 32'(bus.first_got), 0);
      bus.stop = 1'b1;
      cycle();
      bus.stop = 1'b0;
      cycle();
      chk("inj_done", 32'(bus.done), 1);

      // Reset with a failing vector in flight.
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      set_vec(1'b1, 16'h0002, 16'h0003, 1'b0);
      bad_en = 1'b1; bad_val = 17'h00000;
      cycle();
      set_vec(1'b0, 16'h0, 16'h0, 1'b0);
      cycle();
      chk("pre_rst_err", 32'(bus.err_cnt), 1);
      set_vec(1'b1, 16'h0004, 16'h0005, 1'b0);
      cycle();
      mbase = mism_total;
      set_vec(1'b0, 16'h0, 16'h0, 1'b0);
      bad_en = 1'b0;
      rst = 1'b1;
      cycle();
      chk("mrst_mismatch", 32'(bus.mismatch), 0);
      chk("mrst_busy", 32'(bus.busy), 0);
      chk("mrst_done", 32'(bus.done), 0);
      chk("mrst_chk", 32'(bus.chk_cnt), 0);
      chk("mrst_err", 32'(bus.err_cnt), 0);
      chk("mrst_fexp", 32'(bus.first_exp), 0);
      chk("mrst_fgot", 32'(bus.first_got), 0);
      bus.start = 1'b1;
      cycle();
      chk("rst_over_start", 32'(bus.busy), 0);
      rst = 1'b0; bus.start = 1'b0;
      cycle(); cycle();
      chk("mrst_idle_busy", 32'(bus.busy), 0);
      chk("mrst_idle_done", 32'(bus.done), 0);
      chk("mrst_no_pulse", 32'(mism_total - mbase), 0);
      chk("mrst_chk_after", 32'(bus.chk_cnt), 0);

      // Start beats stop in IDLE, then saturate both counters.
      bus.start = 1'b1; bus.stop = 1'b1;
      cycle();
      bus.start = 1'b0; bus.stop = 1'b0;
      cycle(); cycle();
      chk("start_wins_busy", 32'(bus.busy), 1);
      chk("start_wins_done", 32'(bus.done), 0);
      set_vec(1'b1, 16'h0001, 16'h0000, 1'b0);
      bad_en = 1'b1; bad_val = 17'h00000;
      repeat (65540) cycle();
      set_vec(1'b0, 16'h0, 16'h0, 1'b0);
      bad_en = 1'b0;
      bus.stop = 1'b1;
      cycle();
      bus.stop = 1'b0;
      cycle(); cycle();
      chk("sat_done", 32'(bus.done), 1);
      chk("sat_chk", 32'(bus.chk_cnt), 32'hFFFF);
      chk("sat_err", 32'(bus.err_cnt), 32'hFFFF);
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
      chk("sat_clr_chk", 32'(bus.chk_cnt), 0);
      chk("sat_clr_err", 32'(bus.err_cnt), 0);
      chk("sat_clr_busy", 32'(bus.busy), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
